charge_scheduler: RTL

CHARGE_SCHEDULER -- requirements
Module: charge_scheduler

---
 rtl/charge_scheduler.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/charge_scheduler.sv
// Coin-operated charger scheduler: accumulates credit in timer periods and
// launches a period timer once per credit unit until credit is spent.
module charge_scheduler #(
   parameter int unsigned MAX_CREDIT     = 99,
   parameter int unsigned LAUNCH_TIMEOUT = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       coin_1,
   input  logic       coin_5,
   input  logic       confirm,
   input  logic       cancel,
   input  logic       timer_timing,
   output logic       timer_start,
   output logic       timer_clear,
   output logic       charging,
   output logic [6:0] remaining,
   output logic       fault
);

   localparam int unsigned CNT_W = (LAUNCH_TIMEOUT > 1) ? $clog2(LAUNCH_TIMEOUT) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LAUNCH_TIMEOUT - 1);
   localparam logic [6:0] MAX_C = 7'(MAX_CREDIT);

   typedef enum logic [2:0] {
      IDLE,
      CREDIT,
      START,
      WAIT_RISE,
      RUN,
      FAULT
   } state_e;

   state_e           state_q, state_d;
   logic [6:0]       credit_q, credit_d;
   logic [CNT_W-1:0] launchCnt_q, launchCnt_d;
   logic             timing_q;
   logic             clear_q, clear_d;

   logic             periodEnd;
   logic [3:0]       coinSum;
   logic [8:0]       creditSum;
   logic [6:0]       creditNext;

   // Period end is the falling edge of the timer busy flag seen while running.
   assign periodEnd = (state_q == RUN) && timing_q && !timer_timing;

   // Coins and the period-end decrement are netted before saturation, so a
   // coin landing on the same edge as a period end is never lost.
   always_comb begin
      coinSum   = {3'b000, coin_1} + (coin_5 ? 4'd5 : 4'd0);
      creditSum = {2'b00, credit_q} + {5'b00000, coinSum};
      if (periodEnd && (creditSum != 9'd0)) begin
         creditSum = creditSum - 9'd1;
      end
      creditNext = (creditSum > {2'b00, MAX_C}) ? MAX_C : creditSum[6:0];
   end

   always_comb begin
      state_d     = state_q;
      credit_d    = credit_q;
      launchCnt_d = launchCnt_q;
      clear_d     = 1'b0;
      case (state_q)
         IDLE: begin
            credit_d = creditNext;
            if (creditNext != 7'd0) begin
               state_d = CREDIT;
            end
         end
         CREDIT: begin
            if (cancel) begin
               credit_d = 7'd0;
               state_d  = IDLE;
            end else begin
               credit_d = creditNext;
               if (confirm) begin
                  state_d = START;
               end
            end
         end
         START: begin
            if (cancel) begin
               credit_d = 7'd0;
               clear_d  = 1'b1;
               state_d  = IDLE;
            end else begin
               credit_d    = creditNext;
               launchCnt_d = '0;
               state_d     = WAIT_RISE;
            end
         end
         // Cancel is checked first so it beats a same-cycle launch timeout.
         WAIT_RISE: begin
            if (cancel) begin
               credit_d = 7'd0;
               clear_d  = 1'b1;
               state_d  = IDLE;
            end else begin
               credit_d = creditNext;
               if (timer_timing) begin
                  state_d = RUN;
               end else if (launchCnt_q == CNT_LAST) begin
                  state_d = FAULT;
               end else begin
                  launchCnt_d = launchCnt_q + CNT_W'(1);
               end
            end
         end
         RUN: begin
            if (cancel) begin
               credit_d = 7'd0;
               clear_d  = 1'b1;
               state_d  = IDLE;
            end else begin
               credit_d = creditNext;
               if (periodEnd) begin
                  state_d = (creditNext == 7'd0) ? IDLE : START;
               end
            end
         end
         FAULT: begin
            state_d = FAULT;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // timer_clear is registered so it can never coincide with timer_start:
   // whenever it is high the state has already returned to IDLE.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         credit_q    <= 7'd0;
         launchCnt_q <= '0;
         timing_q    <= 1'b0;
         clear_q     <= 1'b1;
      end else begin
         state_q     <= state_d;
         credit_q    <= credit_d;
         launchCnt_q <= launchCnt_d;
         timing_q    <= timer_timing;
         clear_q     <= clear_d;
      end
   end

   assign timer_start = (state_q == START);
   assign charging    = (state_q == START) || (state_q == WAIT_RISE) || (state_q == RUN);
   assign fault       = (state_q == FAULT);
   assign remaining   = credit_q;
   assign timer_clear = clear_q;

endmodule
